// File: rtl/mtm_alu_frame_receiver.sv
// Serial frame receiver for the MTM ALU: assembles DATA/CMD frames into A, B and OP,
// checks data-frame count and CRC, and strobes valid one cycle after the CMD stop bit.
module mtm_alu_frame_receiver #(
   parameter int NDATA = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sin,
   output logic [31:0] a_out,
   output logic [31:0] b_out,
   output logic [2:0]  op_out,
   output logic        valid,
   output logic        err_data,
   output logic        err_crc
);

   localparam int NSLOT = (NDATA > 8) ? NDATA : 8;
   localparam int CW    = $clog2(NDATA + 2);
   localparam logic [CW-1:0] NDATA_C = CW'(NDATA);
   localparam logic [CW-1:0] NSAT_C  = CW'(NDATA + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TYPE    = 2'd1,
      S_PAYLOAD = 2'd2,
      S_STOP    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic            type_q, type_d;
   logic [7:0]      shift_q, shift_d;
   logic [CW-1:0]   data_cnt_q, data_cnt_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      slot_q [NSLOT];
   logic [7:0]      slot_d [NSLOT];
   logic            cmd_pend_q, cmd_pend_d;
   logic            ferr_pend_q, ferr_pend_d;
   logic [31:0]     a_q, a_d;
   logic [31:0]     b_q, b_d;
   logic [2:0]      op_q, op_d;
   logic            valid_q, valid_d;
   logic            err_data_q, err_data_d;
   logic            err_crc_q, err_crc_d;

   logic [31:0]     msg_a;
   logic [31:0]     msg_b;
   logic [2:0]      msg_op;
   logic [3:0]      crc_calc;

   // Serial CRC x^4+x+1, init 0, message consumed MSB first.
   function automatic logic [3:0] crc4(input logic [67:0] m);
      logic [3:0] c;
      logic       fb;
      c = 4'b0000;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ m[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   assign msg_b    = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
   assign msg_a    = {slot_q[4], slot_q[5], slot_q[6], slot_q[7]};
   assign msg_op   = shift_q[6:4];
   assign crc_calc = crc4({msg_b, msg_a, 1'b1, msg_op});

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      type_d      = type_q;
      shift_d     = shift_q;
      data_cnt_d  = data_cnt_q;
      ovf_d       = ovf_q;
      slot_d      = slot_q;
      cmd_pend_d  = 1'b0;
      ferr_pend_d = 1'b0;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      valid_d     = 1'b0;
      err_data_d  = 1'b0;
      err_crc_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!sin) state_d = S_TYPE;
         end
         S_TYPE: begin
            type_d    = sin;
            bit_cnt_d = 3'd7;
            state_d   = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            shift_d   = {shift_q[6:0], sin};
            bit_cnt_d = bit_cnt_q - 3'd1;
            if (bit_cnt_q == 3'd0) state_d = S_STOP;
         end
         S_STOP: begin
            state_d = S_IDLE;
            if (!sin) begin
               ferr_pend_d = 1'b1;
            end else if (type_q) begin
               cmd_pend_d = 1'b1;
            end else begin
               if (data_cnt_q < NDATA_C) begin
                  for (int i = 0; i < NSLOT; i++) begin
                     if (i < NDATA && i == int'(data_cnt_q)) slot_d[i] = shift_q;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
               if (data_cnt_q != NSAT_C) data_cnt_d = data_cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Packet verdict lands one cycle after the stop bit; no frame can commit in between.
      if (ferr_pend_q) begin
         valid_d    = 1'b1;
         err_data_d = 1'b1;
         data_cnt_d = '0;
         ovf_d      = 1'b0;
      end else if (cmd_pend_q) begin
         valid_d = 1'b1;
         if (data_cnt_q != NDATA_C || ovf_q) begin
            err_data_d = 1'b1;
         end else if (crc_calc != shift_q[3:0]) begin
            err_crc_d = 1'b1;
         end else begin
            a_d  = msg_a;
            b_d  = msg_b;
            op_d = msg_op;
         end
         data_cnt_d = '0;
         ovf_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         type_q      <= 1'b0;
         shift_q     <= 8'd0;
         data_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         for (int i = 0; i < NSLOT; i++) slot_q[i] <= 8'd0;
         cmd_pend_q  <= 1'b0;
         ferr_pend_q <= 1'b0;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         op_q        <= 3'd0;
         valid_q     <= 1'b0;
         err_data_q  <= 1'b0;
         err_crc_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         type_q      <= type_d;
         shift_q     <= shift_d;
         data_cnt_q  <= data_cnt_d;
         ovf_q       <= ovf_d;
         slot_q      <= slot_d;
         cmd_pend_q  <= cmd_pend_d;
         ferr_pend_q <= ferr_pend_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         valid_q     <= valid_d;
         err_data_q  <= err_data_d;
         err_crc_q   <= err_crc_d;
      end
   end

   assign a_out    = a_q;
   assign b_out    = b_q;
   assign op_out   = op_q;
   assign valid    = valid_q;
   assign err_data = err_data_q;
   assign err_crc  = err_crc_q;

endmodule
